// File: rtl/typed_ndata_demultiplexer.sv
// Packet-granular demultiplexer: one select handshake picks the destination
// for the next input packet; a single shared output register feeds all streams.
module typed_ndata_demultiplexer #(
    parameter int DATABEAT_SIZE = 8,
    parameter int NUM_STREAMS   = 4,
    parameter int SELECT_WIDTH  = 8,
    parameter int TYPE_WIDTH    = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        select_valid_i,
    output logic                                        select_ready_o,
    input  logic [SELECT_WIDTH-1:0]                     select_data_i,
    input  logic [DATABEAT_SIZE-1:0][7:0]               in_data_i,
    input  logic [TYPE_WIDTH-1:0]                       in_typ_i,
    input  logic [DATABEAT_SIZE-1:0]                    in_keep_i,
    input  logic                                        in_last_i,
    input  logic                                        in_valid_i,
    output logic                                        in_ready_o,
    output logic [NUM_STREAMS-1:0][DATABEAT_SIZE-1:0][7:0] out_data_o,
    output logic [NUM_STREAMS-1:0][TYPE_WIDTH-1:0]      out_typ_o,
    output logic [NUM_STREAMS-1:0][DATABEAT_SIZE-1:0]   out_keep_o,
    output logic [NUM_STREAMS-1:0]                      out_last_o,
    output logic [NUM_STREAMS-1:0]                      out_valid_o,
    input  logic [NUM_STREAMS-1:0]                      out_ready_i,
    output logic [31:0]                                 pkt_count_o,
    output logic [31:0]                                 drop_count_o
);
    // state | meaning
    // IDLE  | waiting for a select handshake; input stalled (inter-packet bubble)
    // ROUTE | forwarding (or discarding) beats of the current packet until last
    typedef enum logic {S_IDLE, S_ROUTE} state_t;

    localparam int IDXW = $clog2(NUM_STREAMS);
    localparam logic [SELECT_WIDTH-1:0] NUM_SEL = SELECT_WIDTH'(NUM_STREAMS);

    state_t                          state_q, state_d;
    logic [SELECT_WIDTH-1:0]         dest_q;
    logic                            rv_q;
    logic [IDXW-1:0]                 idx_q;
    logic [DATABEAT_SIZE-1:0][7:0]   data_q;
    logic [TYPE_WIDTH-1:0]           typ_q;
    logic [DATABEAT_SIZE-1:0]        keep_q;
    logic                            last_q;
    logic [31:0]                     pkt_q;
    logic [31:0]                     drop_q;

    logic dest_ok;
    logic drain;
    logic sel_hs;
    logic accept;

    assign dest_ok = dest_q < NUM_SEL;
    assign drain   = rv_q && out_ready_i[idx_q];
    assign sel_hs  = select_valid_i && select_ready_o;
    assign accept  = in_valid_i && in_ready_o;

    always_comb begin
        state_d        = state_q;
        select_ready_o = 1'b0;
        in_ready_o     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    select_ready_o = 1'b1;
                    if (select_valid_i) state_d = S_ROUTE;
                end
                S_ROUTE: begin
                    // Out-of-range packets are swallowed at full rate.
                    in_ready_o = dest_ok ? (!rv_q || drain) : 1'b1;
                    if (in_valid_i && in_ready_o && in_last_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            rv_q    <= 1'b0;
            idx_q   <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (sel_hs) dest_q <= select_data_i;
            if (accept && dest_ok) begin
                rv_q  <= 1'b1;
                idx_q <= dest_q[IDXW-1:0];
            end else if (drain) begin
                rv_q <= 1'b0;
            end
            if (accept && in_last_i) begin
                if (dest_ok) pkt_q  <= pkt_q + 32'd1;
                else         drop_q <= drop_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && dest_ok) begin
            data_q <= in_data_i;
            typ_q  <= in_typ_i;
            keep_q <= in_keep_i;
            last_q <= in_last_i;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            out_valid_o[i] = rv_q && (idx_q == IDXW'(i));
            out_data_o[i]  = data_q;
            out_typ_o[i]   = typ_q;
            out_keep_o[i]  = keep_q;
            out_last_o[i]  = last_q;
        end
    end

    assign pkt_count_o  = pkt_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_typed_ndata_demultiplexer.sv
// Self-checking bench for typed_ndata_demultiplexer (3 streams, 8-byte beats):
// table-driven packets plus hand sequences for stalls, back-to-back and reset.
module tb_typed_ndata_demultiplexer;
    localparam int NS = 3;
    localparam int DB = 8;
    localparam int TW = 4;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst;
    logic select_valid, select_ready;
    logic [SW-1:0] select_data;
    logic [DB-1:0][7:0] in_data;
    logic [TW-1:0] in_typ;
    logic [DB-1:0] in_keep;
    logic in_last, in_valid, in_ready;
    logic [NS-1:0][DB-1:0][7:0] out_data;
    logic [NS-1:0][TW-1:0] out_typ;
    logic [NS-1:0][DB-1:0] out_keep;
    logic [NS-1:0] out_last, out_valid, out_ready;
    logic [31:0] pkt_count, drop_count;

    typed_ndata_demultiplexer #(
        .DATABEAT_SIZE(DB), .NUM_STREAMS(NS), .SELECT_WIDTH(SW), .TYPE_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .select_valid_i(select_valid), .select_ready_o(select_ready), .select_data_i(select_data),
        .in_data_i(in_data), .in_typ_i(in_typ), .in_keep_i(in_keep), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_typ_o(out_typ), .out_keep_o(out_keep), .out_last_o(out_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .pkt_count_o(pkt_count), .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stream;
        logic [63:0] data;
        logic [3:0]  typ;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    typedef struct {
        int         sel;
        int         nbeats;
        logic [3:0] typ;
        logic [7:0] keep;
        int         exp_pkt;
        int         exp_drop;
    } vec_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_hs = 0;
    int cur_dest = 0;
    int exp_pkt = 0;
    int exp_drop = 0;
    logic        hold_v = 1'b0;
    int          hold_i = 0;
    logic [63:0] hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (select_valid && select_ready) n_hs++;

    // Output monitor: routing, ordering, content and hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            logic any_hold;
            any_hold = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (out_valid[i]) begin
                    if (hold_v && hold_i == i) chk("held_data", out_data[i], hold_data);
                    if (sb.size() == 0) begin
                        chk("unexpected_valid_stream", 64'(i), 64'hFF);
                    end else begin
                        chk("out_stream", 64'(i), 64'(sb[0].stream));
                        if (out_ready[i]) begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("out_data", out_data[i], e.data);
                            chk("out_typ", 64'(out_typ[i]), 64'(e.typ));
                            chk("out_keep", 64'(out_keep[i]), 64'(e.keep));
                            chk("out_last", 64'(out_last[i]), 64'(e.last));
                        end else begin
                            any_hold = 1'b1;
                            hold_i = i;
                            hold_data = out_data[i];
                        end
                    end
                end
            end
            hold_v = any_hold;
        end
    end

    task automatic send_select(input int v);
        int w;
        w = 0;
        select_valid = 1'b1;
        select_data = SW'(v);
        while (1) begin
            @(negedge clk);
            if (select_ready) begin
                chk("idle_in_ready", 64'(in_ready), 64'd0);
                break;
            end
            w++;
            if (w > 200) begin
                chk("select_timeout", 64'd1, 64'd0);
                select_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        select_valid = 1'b0;
        cur_dest = v;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [3:0] t, input logic [7:0] k,
                             input logic l, output int waits);
        in_valid = 1'b1;
        in_data = d;
        in_typ = t;
        in_keep = k;
        in_last = l;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                chk("beat_timeout", 64'd1, 64'd0);
                in_valid = 1'b0;
                return;
            end
        end
        if (cur_dest < NS) begin
            exp_t e;
            e.stream = cur_dest; e.data = d; e.typ = t; e.keep = k; e.last = l;
            sb.push_back(e);
            if (l) exp_pkt++;
        end else if (l) begin
            exp_drop++;
        end
        @(posedge clk);
        if (cur_dest < NS) begin
            fork
                begin
                    automatic int s = cur_dest;
                    @(negedge clk);
                    chk("latency_valid", 64'(out_valid[s]), 64'd1);
                end
            join_none
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            w++;
            if (w > 200) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat(input int b, input int v);
        logic [7:0] by;
        by = 8'((b + 1) * 8'h11 + v * 4);
        return {8{by}};
    endfunction

    vec_t vecs[5];
    int w;

    initial begin
        vecs[0] = '{sel: 2,   nbeats: 3, typ: 4'h3, keep: 8'hFF, exp_pkt: 1, exp_drop: 0};
        vecs[1] = '{sel: 3,   nbeats: 2, typ: 4'h1, keep: 8'hFF, exp_pkt: 1, exp_drop: 1};
        vecs[2] = '{sel: 0,   nbeats: 1, typ: 4'hA, keep: 8'h0F, exp_pkt: 2, exp_drop: 1};
        vecs[3] = '{sel: 200, nbeats: 1, typ: 4'h2, keep: 8'hFF, exp_pkt: 2, exp_drop: 2};
        vecs[4] = '{sel: 1,   nbeats: 2, typ: 4'h7, keep: 8'h3C, exp_pkt: 3, exp_drop: 2};

        rst = 1'b1;
        select_valid = 1'b0; select_data = '0;
        in_valid = 1'b0; in_data = '0; in_typ = '0; in_keep = '0; in_last = 1'b0;
        out_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_select_ready", 64'(select_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_hs = 0;

        for (int v = 0; v < 5; v++) begin
            send_select(vecs[v].sel);
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                send_beat(beat(b, v), vecs[v].typ, vecs[v].keep, b == vecs[v].nbeats - 1, w);
                chk("full_rate_waits", 64'(w), 64'd0);
            end
            wait_drain();
            chk("tbl_pkt_count", 64'(pkt_count), 64'(vecs[v].exp_pkt));
            chk("tbl_drop_count", 64'(drop_count), 64'(vecs[v].exp_drop));
            if (v == 0) chk("select_handshakes", 64'(n_hs), 64'd1);
        end

        // Stall on out[1] after beat 2: input must back-pressure, data held.
        send_select(1);
        send_beat(beat(0, 9), 4'h5, 8'hFF, 1'b0, w);
        send_beat(beat(1, 9), 4'h5, 8'hFF, 1'b0, w);
        out_ready[1] = 1'b0;
        in_valid = 1'b1; in_data = beat(2, 9); in_typ = 4'h5; in_keep = 8'hFF; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        send_beat(beat(2, 9), 4'h5, 8'hFF, 1'b0, w);
        send_beat(beat(3, 9), 4'h5, 8'hFF, 1'b1, w);
        wait_drain();
        chk("stall_pkt_count", 64'(pkt_count), 64'(exp_pkt));

        // Back-to-back packets; packet 2 beat must wait for out[0] to drain.
        send_select(0);
        send_beat(beat(0, 12), 4'h6, 8'hFF, 1'b0, w);
        send_beat(beat(1, 12), 4'h6, 8'hFF, 1'b1, w);
        out_ready[0] = 1'b0;
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join_none
        send_select(2);
        send_beat(beat(0, 13), 4'h9, 8'hF0, 1'b1, w);
        chk("b2b_waited_for_drain", 64'(w > 0), 64'd1);
        wait_drain();
        chk("b2b_pkt_count", 64'(pkt_count), 64'(exp_pkt));
        chk("drop_count_model", 64'(drop_count), 64'(exp_drop));

        // Reset mid-packet with the register occupied.
        send_select(0);
        send_beat(beat(0, 20), 4'h4, 8'hFF, 1'b0, w);
        send_beat(beat(1, 20), 4'h4, 8'hFF, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_pkt = 0;
        exp_drop = 0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("post_rst_drop_count", 64'(drop_count), 64'd0);
        chk("post_rst_select_ready", 64'(select_ready), 64'd1);
        @(posedge clk);
        #1;
        send_select(1);
        send_beat(beat(0, 21), 4'hC, 8'h81, 1'b1, w);
        wait_drain();
        chk("post_rst_pkt_count_after", 64'(pkt_count), 64'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
